// File: rtl/eliminate_ctrl.sv
// eliminate_ctrl: flood-fill elimination sequencer for the colour board.
// Starting from the seed cell it walks 4-connected same-colour cells with an
// explicit stack, marks them, and clears the marked cells in ascending address
// order when the group reaches MIN_GROUP. Owns the board RAM port while busy.
module eliminate_ctrl #(
    parameter int GRID_W    = 8,
    parameter int GRID_H    = 8,
    parameter int COLOR_W   = 3,
    parameter int MIN_GROUP = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         x,
    input  logic [3:0]         y,
    output logic               busy,
    output logic               done,
    output logic [6:0]         elim_count,
    output logic               mem_rd_en,
    output logic [5:0]         mem_rd_addr,
    input  logic [COLOR_W-1:0] mem_rd_data,
    output logic               mem_wr_en,
    output logic [5:0]         mem_wr_addr,
    output logic [COLOR_W-1:0] mem_wr_data
);

    localparam int CELLS = GRID_W * GRID_H;

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_POP, S_NBR, S_CMP, S_EVAL, S_CLEAR, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [CELLS-1:0]   mark_q, mark_d;
    logic [5:0]         stack_q [CELLS];
    logic [6:0]         sp_q, sp_d;
    logic [6:0]         cnt_q, cnt_d;
    logic [5:0]         p_q, p_d;
    logic [5:0]         nbr_q, nbr_d;
    logic [1:0]         dir_q, dir_d;
    logic [5:0]         idx_q, idx_d;
    logic [6:0]         elim_q, elim_d;

    logic               push_en;
    logic [5:0]         push_data;
    logic               nbr_ok;
    logic [5:0]         nbr_addr;

    // Neighbour of the current popped cell in direction dir: left, right, up, down.
    // Row edges are checked explicitly so x=GRID_W-1 never wraps to the next row.
    always_comb begin
        nbr_ok   = 1'b0;
        nbr_addr = p_q;
        case (dir_q)
            2'd0: begin
                nbr_ok   = (int'(p_q) % GRID_W) != 0;
                nbr_addr = p_q - 6'd1;
            end
            2'd1: begin
                nbr_ok   = (int'(p_q) % GRID_W) != GRID_W - 1;
                nbr_addr = p_q + 6'd1;
            end
            2'd2: begin
                nbr_ok   = (int'(p_q) / GRID_W) != 0;
                nbr_addr = p_q - 6'(GRID_W);
            end
            default: begin
                nbr_ok   = (int'(p_q) / GRID_W) != GRID_H - 1;
                nbr_addr = p_q + 6'(GRID_W);
            end
        endcase
    end

    // Next-state and memory-port control for the fill / evaluate / clear sequence.
    always_comb begin
        state_d     = state_q;
        color_d     = color_q;
        mark_d      = mark_q;
        sp_d        = sp_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        nbr_d       = nbr_q;
        dir_d       = dir_q;
        idx_d       = idx_q;
        elim_d      = elim_q;
        push_en     = 1'b0;
        push_data   = '0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (int'(x) >= GRID_W || int'(y) >= GRID_H) begin
                        elim_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        p_d         = 6'(int'(y) * GRID_W + int'(x));
                        mem_rd_en   = 1'b1;
                        mem_rd_addr = 6'(int'(y) * GRID_W + int'(x));
                        mark_d      = '0;
                        sp_d        = '0;
                        cnt_d       = '0;
                        state_d     = S_SEED;
                    end
                end
            end
            S_SEED: begin
                if (mem_rd_data == '0) begin
                    elim_d  = '0;
                    state_d = S_DONE;
                end else begin
                    color_d     = mem_rd_data;
                    mark_d[p_q] = 1'b1;
                    push_en     = 1'b1;
                    push_data   = p_q;
                    sp_d        = sp_q + 7'd1;
                    cnt_d       = 7'd1;
                    state_d     = S_POP;
                end
            end
            S_POP: begin
                if (sp_q == '0) begin
                    state_d = S_EVAL;
                end else begin
                    p_d     = stack_q[sp_q[5:0] - 6'd1];
                    sp_d    = sp_q - 7'd1;
                    dir_d   = 2'd0;
                    state_d = S_NBR;
                end
            end
            S_NBR: begin
                if (nbr_ok && !mark_q[nbr_addr]) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = nbr_addr;
                    nbr_d       = nbr_addr;
                    state_d     = S_CMP;
                end else if (dir_q == 2'd3) begin
                    state_d = S_POP;
                end else begin
                    dir_d = dir_q + 2'd1;
                end
            end
            S_CMP: begin
                // Marking on match (not on read) keeps each cell pushed at most once.
                if (mem_rd_data == color_q) begin
                    mark_d[nbr_q] = 1'b1;
                    push_en       = 1'b1;
                    push_data     = nbr_q;
                    sp_d          = sp_q + 7'd1;
                    cnt_d         = cnt_q + 7'd1;
                end
                if (dir_q == 2'd3) begin
                    state_d = S_POP;
                end else begin
                    dir_d   = dir_q + 2'd1;
                    state_d = S_NBR;
                end
            end
            S_EVAL: begin
                if (int'(cnt_q) >= MIN_GROUP) begin
                    idx_d   = '0;
                    state_d = S_CLEAR;
                end else begin
                    elim_d  = '0;
                    state_d = S_DONE;
                end
            end
            S_CLEAR: begin
                mem_wr_en   = mark_q[idx_q];
                mem_wr_addr = idx_q;
                if (int'(idx_q) == CELLS - 1) begin
                    elim_d  = cnt_q;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            default: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, fill bookkeeping and result registers; reset aborts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            color_q <= '0;
            mark_q  <= '0;
            sp_q    <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            nbr_q   <= '0;
            dir_q   <= '0;
            idx_q   <= '0;
            elim_q  <= '0;
            for (int unsigned i = 0; i < CELLS; i++) stack_q[i] <= '0;
        end else begin
            state_q <= state_d;
            color_q <= color_d;
            mark_q  <= mark_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            nbr_q   <= nbr_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            elim_q  <= elim_d;
            if (push_en) stack_q[sp_q[5:0]] <= push_data;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign elim_count  = elim_q;
    assign mem_wr_data = '0;

endmodule

// File: tb/tb_eliminate_ctrl.sv
// tb_eliminate_ctrl: directed and randomized checks of eliminate_ctrl against a
// queue-based flood-fill reference model and a behavioural sync board RAM.
module tb_eliminate_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] x = '0;
    logic [3:0] y = '0;
    logic       busy, done, mem_rd_en, mem_wr_en;
    logic [6:0] elim_count;
    logic [5:0] mem_rd_addr, mem_wr_addr;
    logic [2:0] mem_rd_data, mem_wr_data;

    int errors = 0;
    int checks = 0;

    logic [2:0] board [64];
    logic [2:0] img   [64];
    logic       load = 1'b0;

    int  wq[$];
    int  cyc, got;
    bit  tmo, ovl, busy_at_done;

    eliminate_ctrl #(.GRID_W(8), .GRID_H(8), .COLOR_W(3), .MIN_GROUP(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .busy(busy), .done(done), .elim_count(elim_count),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;

    // Board RAM: synchronous read, write port clears cells, bench preload via img.
    always @(posedge clk) begin
        if (load) board <= img;
        else if (mem_wr_en) board[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= board[mem_rd_addr];
    end

    task automatic load_board();
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    // Breadth-first fill over img; returns raw group size and its mark set.
    function automatic int ref_group(input int sx, input int sy, output bit mk[64]);
        int q[$];
        int c, cnt;
        for (int i = 0; i < 64; i++) mk[i] = 1'b0;
        if (sx >= 8 || sy >= 8) return 0;
        c = int'(img[sy*8+sx]);
        if (c == 0) return 0;
        mk[sy*8+sx] = 1'b1;
        q.push_back(sy*8+sx);
        cnt = 1;
        while (q.size() > 0) begin
            int p, nx, ny;
            p = q.pop_front();
            for (int d = 0; d < 4; d++) begin
                nx = p % 8 + (d == 0 ? -1 : d == 1 ? 1 : 0);
                ny = p / 8 + (d == 2 ? -1 : d == 3 ? 1 : 0);
                if (nx >= 0 && nx < 8 && ny >= 0 && ny < 8 &&
                    !mk[ny*8+nx] && int'(img[ny*8+nx]) == c) begin
                    mk[ny*8+nx] = 1'b1;
                    q.push_back(ny*8+nx);
                    cnt++;
                end
            end
        end
        return cnt;
    endfunction

    // Issue one start and collect writes until done; intr>0 pulses a second start.
    task automatic run_op(input int sx, input int sy, input int intr);
        wq.delete(); tmo = 0; ovl = 0; cyc = 0; got = -1; busy_at_done = 0;
        @(negedge clk); x = 4'(sx); y = 4'(sy); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (1) begin
            cyc++;
            if (mem_rd_en && mem_wr_en) ovl = 1;
            if (mem_wr_en) wq.push_back(int'(mem_wr_addr));
            if (done) begin got = int'(elim_count); busy_at_done = busy; break; end
            if (cyc >= 2000) begin tmo = 1; break; end
            if (cyc == intr) begin x = 4'd0; y = 4'd0; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, mem_rd_en, mem_wr_en, elim_count, mem_rd_addr, mem_wr_addr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b rd=%b wr=%b cnt=%0d ra=%0d wa=%0d, want all 0",
                     busy, done, mem_rd_en, mem_wr_en, elim_count, mem_rd_addr, mem_wr_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pair();
        for (int i = 0; i < 64; i++) img[i] = 3'd1;
        img[27] = 3'd5; img[28] = 3'd5;
        load_board();
        run_op(3, 3, 0);
        checks++;
        if (got != 2 || tmo) begin
            errors++; $display("FAIL pair_count: got %0d (timeout=%0b), want 2", got, tmo);
        end
        checks++;
        if (wq.size() != 2 || wq[0] != 27 || wq[1] != 28) begin
            errors++; $display("FAIL pair_writes: got %p, want '{27,28}", wq);
        end
        checks++;
        if (busy_at_done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL pair_busy: got at_done=%b after=%b, want 1 then 0", busy_at_done, busy);
        end
    endtask

    task automatic test_isolated();
        for (int i = 0; i < 64; i++) img[i] = 3'd3;
        img[27] = 3'd2;
        load_board();
        run_op(3, 3, 0);
        checks++;
        if (got != 0 || tmo || wq.size() != 0) begin
            errors++; $display("FAIL isolated: got cnt=%0d writes=%0d timeout=%0b, want 0/0/0", got, wq.size(), tmo);
        end
    endtask

    task automatic test_full();
        bit ok;
        for (int i = 0; i < 64; i++) img[i] = 3'd1;
        load_board();
        run_op(0, 0, 0);
        checks++;
        if (got != 64 || tmo || cyc > 64*9+66) begin
            errors++; $display("FAIL full_count: got %0d in %0d cycles (timeout=%0b), want 64 within 642", got, cyc, tmo);
        end
        ok = (wq.size() == 64);
        for (int i = 0; i < wq.size(); i++) if (wq[i] != i) ok = 0;
        checks++;
        if (!ok || ovl) begin
            errors++; $display("FAIL full_writes: got %0d writes overlap=%0b, want 0..63 ascending", wq.size(), ovl);
        end
    endtask

    task automatic test_empty_and_oob();
        for (int i = 0; i < 64; i++) img[i] = 3'd1;
        img[5*8+2] = 3'd0;
        load_board();
        run_op(2, 5, 0);
        checks++;
        if (got != 0 || cyc > 3 || wq.size() != 0) begin
            errors++; $display("FAIL empty_seed: got cnt=%0d cycles=%0d writes=%0d, want 0/<=3/0", got, cyc, wq.size());
        end
        run_op(0, 0, 0);
        run_op(9, 1, 0);
        checks++;
        if (got != 0 || cyc > 3 || wq.size() != 0) begin
            errors++; $display("FAIL x_oob: got cnt=%0d cycles=%0d writes=%0d, want 0/<=3/0", got, cyc, wq.size());
        end
    endtask

    task automatic test_no_wrap();
        for (int i = 0; i < 64; i++) img[i] = ((i % 8 + i / 8) % 2 == 1) ? 3'd1 : 3'd2;
        img[7] = 3'd4; img[8] = 3'd4;
        load_board();
        run_op(7, 0, 0);
        checks++;
        if (got != 0 || wq.size() != 0 || tmo) begin
            errors++; $display("FAIL no_wrap: got cnt=%0d writes=%0d, want 0/0", got, wq.size());
        end
    endtask

    task automatic test_random();
        bit mk[64];
        int raw, exp_cnt, sx, sy;
        bit ok;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 64; i++) img[i] = 3'($urandom_range(0, 3));
            sx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            sy = int'($urandom_range(0, 7));
            load_board();
            raw = ref_group(sx, sy, mk);
            exp_cnt = (raw >= 2) ? raw : 0;
            run_op(sx, sy, 0);
            checks++;
            if (got != exp_cnt || tmo) begin
                errors++; $display("FAIL rand_count[%0d]: seed(%0d,%0d) got %0d, want %0d", n, sx, sy, got, exp_cnt);
            end
            ok = !ovl;
            begin
                int k;
                k = 0;
                for (int i = 0; i < 64; i++) if (exp_cnt > 0 && mk[i]) begin
                    if (k >= wq.size() || wq[k] != i) ok = 0;
                    k++;
                end
                if (k != wq.size()) ok = 0;
            end
            for (int i = 0; i < 64; i++)
                if (board[i] !== ((exp_cnt > 0 && mk[i]) ? 3'd0 : img[i])) ok = 0;
            checks++;
            if (!ok) begin
                errors++; $display("FAIL rand_writes[%0d]: seed(%0d,%0d) got %0d writes overlap=%0b, want %0d and matching board",
                                   n, sx, sy, wq.size(), ovl, exp_cnt);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int late_busy;
        for (int i = 0; i < 64; i++) img[i] = 3'd3;
        img[27] = 3'd5; img[28] = 3'd5;
        load_board();
        run_op(3, 3, 4);
        checks++;
        if (got != 2 || wq.size() != 2 || wq[0] != 27 || wq[1] != 28) begin
            errors++; $display("FAIL busy_ignore: got cnt=%0d writes=%p, want 2 '{27,28}", got, wq);
        end
        late_busy = 0;
        repeat (20) begin @(negedge clk); if (busy) late_busy++; end
        checks++;
        if (late_busy != 0) begin
            errors++; $display("FAIL busy_ignore_idle: got %0d busy cycles after done, want 0", late_busy);
        end
    endtask

    task automatic test_reset_clear();
        int nw, guard;
        bit ok;
        for (int i = 0; i < 64; i++) img[i] = 3'd1;
        load_board();
        @(negedge clk); x = 4'd0; y = 4'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        nw = 0; guard = 0;
        while (guard < 2000) begin
            if (mem_wr_en) begin
                if (nw == 5) break;
                nw++;
            end
            guard++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (guard >= 2000 || mem_wr_en !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_in_clear: got wr_en=%b busy=%b guard=%0d, want 0/0", mem_wr_en, busy, guard);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (mem_wr_en !== 1'b0 || done !== 1'b0 || elim_count !== 7'd0) begin
                errors++; $display("FAIL reset_hold: got wr=%b done=%b cnt=%0d, want 0/0/0", mem_wr_en, done, elim_count);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        ok = 1;
        for (int i = 0; i < 64; i++) if (board[i] !== ((i < 5) ? 3'd0 : 3'd1)) ok = 0;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL reset_board: cells 0..4 cleared and rest kept not observed");
        end
        run_op(7, 7, 0);
        checks++;
        if (got != 59 || tmo) begin
            errors++; $display("FAIL after_reset: got %0d, want 59", got);
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_isolated();
        test_full();
        test_pair();
        test_empty_and_oob();
        test_pair();
        test_no_wrap();
        test_random();
        test_busy_ignore();
        test_reset_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
